// File: rtl/rgb_pwm_driver.sv
// RGB LED PWM driver: colour code plus global brightness to three registered PWM pins.
// Optional per-frame fading of channel levels is enabled by defining RGB_FADE_EN.
module rgb_pwm_driver #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned PRESCALE  = 4,
  parameter int unsigned FADE_STEP = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       colour_i,
  input  logic [CNT_W-1:0] duty_i,
  input  logic             enable_i,
  output logic             red_o,
  output logic             green_o,
  output logic             blue_o,
  output logic             frame_start_o
);

  localparam int unsigned     PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = '1;
  localparam logic [CNT_W-1:0] STEP     = CNT_W'(FADE_STEP);

  logic [PRE_W-1:0]       pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0]       pwm_cnt_q, pwm_cnt_d;
  logic [2:0][CNT_W-1:0]  level_q, level_d;
  logic [2:0][CNT_W-1:0]  target_c;
  logic [2:0]             drive_q, drive_d;
  logic                   frame_start_q, frame_start_d;
  logic                   tick_c;
  logic                   boundary_c;

  // Move cur toward tgt by at most STEP, never overshooting.
  function automatic logic [CNT_W-1:0] step_toward(input logic [CNT_W-1:0] cur,
                                                   input logic [CNT_W-1:0] tgt);
    logic [CNT_W-1:0] res;
    res = cur;
    if (tgt > cur) begin
      res = ((tgt - cur) > STEP) ? (cur + STEP) : tgt;
    end else if (cur > tgt) begin
      res = ((cur - tgt) > STEP) ? (cur - STEP) : tgt;
    end
    return res;
  endfunction

  always_comb begin
    tick_c     = (pre_cnt_q == PRE_LAST);
    boundary_c = tick_c && (pwm_cnt_q == CNT_LAST);
  end

  always_comb begin
    pre_cnt_d = tick_c ? '0 : (pre_cnt_q + PRE_W'(1));
    pwm_cnt_d = tick_c ? (pwm_cnt_q + CNT_W'(1)) : pwm_cnt_q;
  end

  always_comb begin
    target_c = '0;
    for (int i = 0; i < 3; i++) begin
      target_c[i] = colour_i[i] ? duty_i : '0;
    end
  end

  // Levels only change at the frame boundary so a frame is never cut short.
  always_comb begin
    level_d = level_q;
    if (boundary_c) begin
      for (int i = 0; i < 3; i++) begin
`ifdef RGB_FADE_EN
        level_d[i] = step_toward(level_q[i], target_c[i]);
`else
        level_d[i] = target_c[i];
`endif
      end
    end
  end

  // Full-scale level is forced on so the pin never shows a one-tick gap.
  always_comb begin
    drive_d = '0;
    for (int i = 0; i < 3; i++) begin
      drive_d[i] = enable_i & ((level_q[i] == CNT_LAST) | (pwm_cnt_q < level_q[i]));
    end
    frame_start_d = boundary_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q     <= '0;
      pwm_cnt_q     <= '0;
      level_q       <= '0;
      drive_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      pre_cnt_q     <= pre_cnt_d;
      pwm_cnt_q     <= pwm_cnt_d;
      level_q       <= level_d;
      drive_q       <= drive_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign red_o         = drive_q[0];
  assign green_o       = drive_q[1];
  assign blue_o        = drive_q[2];
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver at default parameters (1024-clk frames).
// With RGB_FADE_EN defined the fade ramp sequence replaces the hard-switch sequence.
module tb_rgb_pwm_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] colour;
  logic [7:0] duty;
  logic       enable;
  logic       red, green, blue, frame_start;

  int n_pass  = 0;
  int n_total = 0;

  int tr_r [0:1024];
  int tr_g [0:1024];
  int tr_b [0:1024];
  int hi_r, hi_g, hi_b, gap;
  int first_fs;
  int pin_seen;

  always #5 clk = ~clk;

  rgb_pwm_driver dut (
    .clk          (clk),
    .rst          (rst),
    .colour_i     (colour),
    .duty_i       (duty),
    .enable_i     (enable),
    .red_o        (red),
    .green_o      (green),
    .blue_o       (blue),
    .frame_start_o(frame_start)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Runs from just after a frame_start until the next one, recording pin traces.
  task automatic run_frame(input int chg_at, input logic [2:0] chg_col,
                           input int off_at, input int on_at);
    hi_r = 0; hi_g = 0; hi_b = 0; gap = 0;
    for (int k = 1; k <= 1100; k++) begin
      @(posedge clk); #1;
      if (k == chg_at) colour = chg_col;
      if (k == off_at) enable = 1'b0;
      if (k == on_at)  enable = 1'b1;
      if (k <= 1024) begin
        tr_r[k] = int'(red);
        tr_g[k] = int'(green);
        tr_b[k] = int'(blue);
        hi_r += int'(red);
        hi_g += int'(green);
        hi_b += int'(blue);
      end
      if (frame_start === 1'b1) begin
        gap = k;
        break;
      end
    end
  endtask

  task automatic wait_fs(output int cycles, output int pins);
    cycles = 0;
    pins   = 0;
    for (int k = 1; k <= 2000; k++) begin
      @(posedge clk); #1;
      if (red !== 1'b0 || green !== 1'b0 || blue !== 1'b0) pins = 1;
      if (frame_start === 1'b1) begin
        cycles = k;
        break;
      end
    end
  endtask

`ifdef RGB_FADE_EN
  int fall_lv [0:6] = '{112, 96, 80, 64, 48, 40, 40};
`endif

  initial begin
    rst    = 1'b1;
    colour = 3'b111;
    duty   = 8'd128;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_red",   32'(red),         32'd0);
    chk("rst_green", 32'(green),       32'd0);
    chk("rst_blue",  32'(blue),        32'd0);
    chk("rst_fs",    32'(frame_start), 32'd0);
    rst = 1'b0;

    wait_fs(first_fs, pin_seen);
    chk("first_fs_cycle",       32'(first_fs), 32'd1024);
    chk("pins_low_first_frame", 32'(pin_seen), 32'd0);

`ifdef RGB_FADE_EN
    for (int f = 1; f <= 8; f++) begin
      run_frame(0, colour, 0, 0);
      chk("fade_up_red",  32'(hi_r), 32'(64 * f));
      chk("fade_up_blue", 32'(hi_b), 32'(64 * f));
      chk("fade_up_gap",  32'(gap),  32'd1024);
    end
    run_frame(0, colour, 0, 0);
    chk("fade_steady", 32'(hi_g), 32'd512);
    duty = 8'd40;
    run_frame(0, colour, 0, 0);
    chk("fade_dn_hold", 32'(hi_r), 32'd512);
    for (int f = 0; f < 7; f++) begin
      run_frame(0, colour, 0, 0);
      chk("fade_dn_red",   32'(hi_r), 32'(4 * fall_lv[f]));
      chk("fade_dn_green", 32'(hi_g), 32'(4 * fall_lv[f]));
    end
`else
    run_frame(0, colour, 0, 0);
    chk("t1_period", 32'(gap),  32'd1024);
    chk("t1_red",    32'(hi_r), 32'd512);
    chk("t1_blue",   32'(hi_b), 32'd512);

    colour = 3'b001; duty = 8'd64;
    run_frame(0, colour, 0, 0);
    chk("t2_hold_red", 32'(hi_r), 32'd512);
    run_frame(0, colour, 0, 0);
    chk("t2_red_hi",    32'(hi_r),     32'd256);
    chk("t2_green",     32'(hi_g),     32'd0);
    chk("t2_blue",      32'(hi_b),     32'd0);
    chk("t2_red_first", 32'(tr_r[1]),  32'd1);
    chk("t2_red_256",   32'(tr_r[256]), 32'd1);
    chk("t2_red_257",   32'(tr_r[257]), 32'd0);

    colour = 3'b110; duty = 8'd255;
    run_frame(0, colour, 0, 0);
    chk("t3_hold_red", 32'(hi_r), 32'd256);
    run_frame(0, colour, 0, 0);
    chk("t3_red",   32'(hi_r), 32'd0);
    chk("t3_green", 32'(hi_g), 32'd1024);
    chk("t3_blue",  32'(hi_b), 32'd1024);
    duty = 8'd0;
    run_frame(0, colour, 0, 0);
    chk("t3_hold_green", 32'(hi_g), 32'd1024);
    run_frame(0, colour, 0, 0);
    chk("t3_off_sum", 32'(hi_r + hi_g + hi_b), 32'd0);

    colour = 3'b001; duty = 8'd64;
    run_frame(0, colour, 0, 0);
    run_frame(0, colour, 0, 0);
    chk("t4_setup_red", 32'(hi_r), 32'd256);
    run_frame(300, 3'b010, 0, 0);
    chk("t4_red_kept",  32'(hi_r), 32'd256);
    chk("t4_green_off", 32'(hi_g), 32'd0);
    chk("t4_gap",       32'(gap),  32'd1024);
    run_frame(0, colour, 0, 0);
    chk("t4_red_new",   32'(hi_r),    32'd0);
    chk("t4_green_new", 32'(hi_g),    32'd256);
    chk("t4_green_k1",  32'(tr_g[1]), 32'd1);

    run_frame(0, colour, 100, 110);
    chk("t5_before_off", 32'(tr_g[100]), 32'd1);
    chk("t5_off",        32'(tr_g[101]), 32'd0);
    chk("t5_still_off",  32'(tr_g[110]), 32'd0);
    chk("t5_restored",   32'(tr_g[111]), 32'd1);
    chk("t5_green_hi",   32'(hi_g),      32'd246);
    chk("t5_gap",        32'(gap),       32'd1024);
`endif

    repeat (100) @(posedge clk);
    #1;
    chk("pre_rst_green", 32'(green), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_green", 32'(green),       32'd0);
    chk("mid_rst_fs",    32'(frame_start), 32'd0);
    rst = 1'b0;
    wait_fs(first_fs, pin_seen);
    chk("post_rst_fs",   32'(first_fs), 32'd1024);
    chk("post_rst_pins", 32'(pin_seen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
